// File: rtl/rsa_io_bridge_pkg.sv
// rsa_io_bridge_pkg: shared state encoding and operand field layout for the RSA stream bridge.
package rsa_io_bridge_pkg;
    typedef enum logic [1:0] {LOAD, RUN, SEND} state_t;
    localparam int OP_W       = 256;
    localparam int LOAD_WORDS = 18;
    localparam int X_OFF      = 0;
    localparam int N_OFF      = 8;
    localparam int E_OFF      = 16;
    localparam int MP_OFF     = 17;
endpackage

// File: rtl/rsa_io_bridge.sv
// rsa_io_bridge: loads x/n/e/mp from a word stream, runs the exponentiation core under a
// watchdog, then streams the 256-bit result back out least-significant word first.
module rsa_io_bridge
    import rsa_io_bridge_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int NWORDS  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [OP_W-1:0]   x_o,
    output logic [OP_W-1:0]   n_o,
    output logic [WORD_W-1:0] e_o,
    output logic [WORD_W-1:0] mp_o,
    output logic              core_rst_n,
    input  logic              core_done,
    input  logic [OP_W-1:0]   core_result,
    output logic              busy,
    output logic              err
);
    localparam int WCW = $clog2(LOAD_WORDS);
    localparam int IW  = $clog2(NWORDS);
    localparam int CW  = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WCW-1:0]    wc_q, wc_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [OP_W-1:0]   x_q, x_d, n_q, n_d, res_q, res_d;
    logic [WORD_W-1:0] e_q, e_d, mp_q, mp_d;
    logic              err_q, err_d;
    logic [IW-1:0]     fi;

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        cyc_d   = cyc_q;
        x_d     = x_q;
        n_d     = n_q;
        e_d     = e_q;
        mp_d    = mp_q;
        res_d   = res_q;
        err_d   = err_q;
        // word index within the x or n field being loaded
        fi = IW'(wc_q - WCW'(wc_q < WCW'(N_OFF) ? X_OFF : N_OFF));
        if (state_q == LOAD && s_valid) begin
            wc_d = wc_q + 1'b1;
            if (wc_q == WCW'(X_OFF)) err_d = 1'b0;
            if (wc_q < WCW'(N_OFF)) x_d[fi*WORD_W +: WORD_W] = s_data;
            else if (wc_q < WCW'(E_OFF)) n_d[fi*WORD_W +: WORD_W] = s_data;
            else if (wc_q == WCW'(E_OFF)) e_d = s_data;
            else mp_d = s_data;
            if (wc_q == WCW'(MP_OFF)) begin
                wc_d    = '0;
                cyc_d   = '0;
                state_d = RUN;
            end
        end
        if (state_q == RUN) begin
            cyc_d = cyc_q + 1'b1;
            // a done seen on the timeout cycle still counts as success
            if (core_done) begin
                res_d   = core_result;
                cyc_d   = '0;
                state_d = SEND;
            end else if (cyc_q == CW'(TIMEOUT - 1)) begin
                res_d   = '0;
                err_d   = 1'b1;
                cyc_d   = '0;
                state_d = SEND;
            end
        end
        if (state_q == SEND && m_ready) begin
            wc_d = wc_q + 1'b1;
            if (wc_q == WCW'(NWORDS - 1)) begin
                wc_d    = '0;
                state_d = LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LOAD;
            wc_q    <= '0;
            cyc_q   <= '0;
            x_q     <= '0;
            n_q     <= '0;
            e_q     <= '0;
            mp_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            cyc_q   <= cyc_d;
            x_q     <= x_d;
            n_q     <= n_d;
            e_q     <= e_d;
            mp_q    <= mp_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign s_ready    = state_q == LOAD;
    assign m_valid    = state_q == SEND;
    assign m_last     = m_valid && wc_q == WCW'(NWORDS - 1);
    assign m_data     = m_valid ? res_q[wc_q[IW-1:0]*WORD_W +: WORD_W] : '0;
    assign core_rst_n = state_q == RUN;
    assign busy       = state_q != LOAD;
    assign err        = err_q;
    assign x_o        = x_q;
    assign n_o        = n_q;
    assign e_o        = e_q;
    assign mp_o       = mp_q;
endmodule

// File: tb/tb_rsa_io_bridge.sv
// tb_rsa_io_bridge: randomized scoreboard bench; two bridges (long and short watchdog) share
// stimulus, with a select steering handshakes to the one under test.
module tb_rsa_io_bridge;
    import rsa_io_bridge_pkg::*;
    localparam int TA = 256;
    localparam int TB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0, m_ready = 1'b0, sel = 1'b0;
    logic [255:0] core_res = '0;
    int           lat = 0;

    logic         s_ready_a, m_valid_a, m_last_a, core_rst_n_a, busy_a, err_a, core_done_a;
    logic         s_ready_b, m_valid_b, m_last_b, core_rst_n_b, busy_b, err_b, core_done_b;
    logic [31:0]  m_data_a, e_a, mp_a, m_data_b, e_b, mp_b;
    logic [255:0] x_a, n_a, x_b, n_b;
    int           rc_a = 0, rc_b = 0;

    // model core: done rises lat cycles after its reset is released, held as a level
    always @(posedge clk) begin
        rc_a <= core_rst_n_a ? rc_a + 1 : 0;
        rc_b <= core_rst_n_b ? rc_b + 1 : 0;
    end
    assign core_done_a = core_rst_n_a && (rc_a >= lat);
    assign core_done_b = core_rst_n_b && (rc_b >= lat);

    rsa_io_bridge #(.WORD_W(32), .NWORDS(8), .TIMEOUT(TA)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && !sel), .s_ready(s_ready_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready && !sel), .m_last(m_last_a),
        .x_o(x_a), .n_o(n_a), .e_o(e_a), .mp_o(mp_a), .core_rst_n(core_rst_n_a),
        .core_done(core_done_a), .core_result(core_res), .busy(busy_a), .err(err_a));

    rsa_io_bridge #(.WORD_W(32), .NWORDS(8), .TIMEOUT(TB)) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && sel), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready && sel), .m_last(m_last_b),
        .x_o(x_b), .n_o(n_b), .e_o(e_b), .mp_o(mp_b), .core_rst_n(core_rst_n_b),
        .core_done(core_done_b), .core_result(core_res), .busy(busy_b), .err(err_b));

    logic         s_ready_w, m_valid_w, m_last_w, core_rst_n_w, busy_w, err_w;
    logic [31:0]  m_data_w, e_w, mp_w;
    logic [255:0] x_w, n_w;
    assign s_ready_w    = sel ? s_ready_b : s_ready_a;
    assign m_valid_w    = sel ? m_valid_b : m_valid_a;
    assign m_last_w     = sel ? m_last_b : m_last_a;
    assign core_rst_n_w = sel ? core_rst_n_b : core_rst_n_a;
    assign busy_w       = sel ? busy_b : busy_a;
    assign err_w        = sel ? err_b : err_a;
    assign m_data_w     = sel ? m_data_b : m_data_a;
    assign e_w          = sel ? e_b : e_a;
    assign mp_w         = sel ? mp_b : mp_a;
    assign x_w          = sel ? x_b : x_a;
    assign n_w          = sel ? n_b : n_a;

    typedef struct {logic [31:0] d; logic l; logic e;} exp_t;
    exp_t sbq[$];
    int   vectors = 0, miscompares = 0;
    logic last_err [2] = '{1'b0, 1'b0};

    function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // monitor: every presented word must match the head of the queue; pop on handshake
    always @(negedge clk) begin
        if (rst && m_valid_w) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word got %h want none", m_data_w);
            end else begin
                chk("m_data", m_data_w, sbq[0].d);
                chk("m_last", m_last_w, sbq[0].l);
                chk("err_send", err_w, sbq[0].e);
                if (m_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic load_job(input logic [255:0] x, input logic [255:0] n, input logic [31:0] e,
                            input logic [31:0] mp, input int gap_after);
        logic [31:0]  w [18];
        logic [255:0] er;
        logic         ee;
        int           t;
        for (int i = 0; i < 8; i++) begin
            w[i]     = x[i*32 +: 32];
            w[8 + i] = n[i*32 +: 32];
        end
        w[16] = e;
        w[17] = mp;
        t  = sel ? TB : TA;
        ee = !(lat < t);
        er = ee ? '0 : core_res;
        for (int i = 0; i < 18; i++) begin
            s_valid = 1'b1;
            s_data  = w[i];
            @(negedge clk);
            chk("s_ready_load", s_ready_w, 1);
            if (i == 0) chk("err_before_w0", err_w, last_err[sel]);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_data  = $urandom;
            if (i == 0) chk("err_after_w0", err_w, 0);
            if (i == gap_after) repeat (5) begin
                @(posedge clk);
                #1;
            end
        end
        chk("run_entry", core_rst_n_w, 1);
        chk("busy_run", busy_w, 1);
        chk("s_ready_run", s_ready_w, 0);
        chk("x_o", x_w, x);
        chk("n_o", n_w, n);
        chk("e_o", e_w, e);
        chk("mp_o", mp_w, mp);
        for (int i = 0; i < 8; i++) sbq.push_back('{er[i*32 +: 32], (i == 7), ee});
        last_err[sel] = ee;
    endtask

    task automatic drain_job(input logic [255:0] x, input int stall_idx, input int stall_len,
                             input int bp);
        int   rl, g, acc, held, t;
        logic f;
        t  = sel ? TB : TA;
        rl = 0;
        g  = 0;
        while (!m_valid_w && g < 2000) begin
            if (core_rst_n_w) rl++;
            @(posedge clk);
            #1;
            g++;
        end
        chk("run_len", rl, (lat < t) ? lat + 1 : t);
        acc  = 0;
        held = 0;
        g    = 0;
        while (acc < 8 && g < 2000) begin
            if (acc == stall_idx && held < stall_len) begin
                m_ready = 1'b0;
                held++;
            end else m_ready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            f = m_valid_w && m_ready;
            @(posedge clk);
            #1;
            if (f) acc++;
            g++;
        end
        m_ready = 1'b0;
        chk("words_sent", acc, 8);
        chk("s_ready_after", s_ready_w, 1);
        chk("busy_after", busy_w, 0);
        chk("m_valid_after", m_valid_w, 0);
        chk("sb_empty", sbq.size(), 0);
        chk("x_hold", x_w, x);
    endtask

    task automatic job(input logic [255:0] x, input logic [255:0] n, input logic [31:0] e,
                       input logic [31:0] mp, input int gap_after, input int stall_idx,
                       input int stall_len, input int bp);
        load_job(x, n, e, mp, gap_after);
        drain_job(x, stall_idx, stall_len, bp);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_s_ready"}, s_ready_w, 1);
        chk({tag, "_m_valid"}, m_valid_w, 0);
        chk({tag, "_m_last"}, m_last_w, 0);
        chk({tag, "_m_data"}, m_data_w, 0);
        chk({tag, "_core_rst_n"}, core_rst_n_w, 0);
        chk({tag, "_busy"}, busy_w, 0);
        chk({tag, "_err"}, err_w, 0);
        chk({tag, "_x_o"}, x_w, 0);
        chk({tag, "_mp_o"}, mp_w, 0);
    endtask

    logic [255:0] rx;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_idle("reset");
        lat      = 100;
        core_res = 256'h8;
        job(256'h2, ~256'h4, 32'h3, 32'h1, -1, -1, 0, 0);
        lat      = $urandom_range(0, 150);
        core_res = rnd256();
        job(rnd256(), rnd256(), $urandom, $urandom, 9, -1, 0, 0);
        lat      = $urandom_range(0, 150);
        core_res = rnd256();
        job(rnd256(), rnd256(), $urandom, $urandom, -1, 3, 20, 0);
        for (int k = 0; k < 4; k++) begin
            lat      = $urandom_range(0, TA + 20);
            core_res = rnd256();
            job(rnd256(), rnd256(), $urandom, $urandom, -1, -1, 0, 1);
        end
        sel = 1'b1;
        lat = 100;
        core_res = rnd256();
        job(rnd256(), rnd256(), $urandom, $urandom, -1, -1, 0, 0);
        lat = TB - 1;
        core_res = rnd256();
        job(rnd256(), rnd256(), $urandom, $urandom, -1, -1, 0, 0);
        lat = TB;
        job(rnd256(), rnd256(), $urandom, $urandom, -1, -1, 0, 1);
        lat = 3;
        core_res = rnd256();
        job(rnd256(), rnd256(), $urandom, $urandom, -1, 2, 4, 0);
        sel = 1'b0;
        lat = 100;
        rx  = rnd256();
        load_job(rx, rnd256(), $urandom, $urandom, -1);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        last_err = '{1'b0, 1'b0};
        check_idle("rst_in_run");
        lat      = $urandom_range(0, 50);
        core_res = rnd256();
        job(rnd256(), rnd256(), $urandom, $urandom, -1, -1, 0, 1);
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rsa_io_bridge.md
RSA_IO_BRIDGE -- requirements
Module: rsa_io_bridge

Interface
REQ-001 The block SHALL provide parameter WORD_W, default 32, as the stream word width in bits.
REQ-002 The block SHALL provide parameter NWORDS, default 8, as the number of words per 256-bit operand.
REQ-003 The block SHALL provide parameter TIMEOUT, default 4096, as the maximum number of RUN cycles before abort.
REQ-004 The block SHALL have clk  input  1  clock; all logic is on the rising edge.
REQ-005 The block SHALL have rst  input  1  reset: synchronous, active-low; clock clk.
REQ-006 The block SHALL have s_data  input  32  operand load word.
REQ-007 The block SHALL have s_valid  input  1 and s_ready  output  1 as the load handshake; a word transfers when both are high.
REQ-008 The block SHALL have m_data  output  32  result word.
REQ-009 The block SHALL have m_valid  output  1, m_ready  input  1 and m_last  output  1 as the result handshake.
REQ-010 The block SHALL have x_o  output  256  base operand to the exponentiation core.
REQ-011 The block SHALL have n_o  output  256  modulus to the core.
REQ-012 The block SHALL have e_o  output  32  exponent to the core.
REQ-013 The block SHALL have mp_o  output  32  Montgomery constant to the core.
REQ-014 The block SHALL have core_rst_n  output  1  active-low run/reset control to the core.
REQ-015 The block SHALL have core_done  input  1  core end flag, level.
REQ-016 The block SHALL have core_result  input  256  core result.
REQ-017 The block SHALL have busy  output  1 and err  output  1 as status outputs.

Function
REQ-018 The block SHALL sequence the states LOAD -> RUN -> SEND -> LOAD.
REQ-019 In LOAD, s_ready SHALL be 1 and each accepted word SHALL increment a word counter wc from 0 to 17.
- Words 0-7 fill x_o, least-significant word first.
- Words 8-15 fill n_o, least-significant word first.
- Word 16 fills e_o.
- Word 17 fills mp_o.
REQ-020 On acceptance of word 17, the block SHALL enter RUN on the next cycle and reset wc to 0.
REQ-021 In RUN and SEND, s_ready SHALL be 0, and s_valid SHALL be ignored.
REQ-022 core_rst_n SHALL be 1 only in RUN, so the core sees reset held in every other state.
REQ-023 In RUN, a cycle counter SHALL start at 0 on entry and increment every cycle.
REQ-024 On the first RUN cycle with core_done=1, the block SHALL capture core_result into a 256-bit result register and enter SEND.
REQ-025 If the cycle counter reaches TIMEOUT-1 with core_done=0, the block SHALL load the result register with zero, set err=1 and enter SEND.
REQ-026 If core_done=1 in the same cycle as the timeout, core_done SHALL win and err SHALL remain 0.
REQ-027 In SEND, m_valid SHALL be 1 and m_data SHALL be result word wc, least-significant word first.
REQ-028 m_last SHALL be 1 exactly when wc=7 in SEND.
REQ-029 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-030 On acceptance of word 7, the block SHALL return to LOAD on the next cycle with wc=0 and s_ready=1.
REQ-031 busy SHALL be 1 in RUN and SEND, and 0 in LOAD.
REQ-032 err SHALL be sticky until word 0 of the next job is accepted, then clear to 0.
REQ-033 The operand outputs x_o, n_o, e_o and mp_o SHALL remain stable from RUN entry until overwritten in the next LOAD.

Reset
REQ-034 While rst=0 at a clock edge, the block SHALL enter LOAD with wc=0 and the cycle counter at 0.
REQ-035 Reset SHALL also clear x_o, n_o, e_o, mp_o and the result register to 0.
REQ-036 Reset SHALL set core_rst_n=0, m_valid=0, m_last=0, m_data=0, busy=0 and err=0; s_ready SHALL be 1 from the first cycle after reset.
REQ-037 A reset asserted in any state, including mid-LOAD, mid-RUN or a stalled SEND, SHALL abort the job with no partial result emitted.

Structure
REQ-038 A shared package SHALL hold the state enum (LOAD, RUN, SEND), the operand width 256, the load word count 18, and the field word offsets 0, 8, 16 and 17.
REQ-039 The block SHALL be a single module with no sub-modules; the exponentiation core is instantiated beside it, not inside it.

Verification
REQ-040 The bench SHALL check that with x=2, n=0xFF..FB, e=0x00000003, mp=1 loaded and a model core asserting done after 100 cycles with result 0x8, exactly eight m words are output, the first 0x00000008, the remaining seven 0, with m_last on the eighth.
REQ-041 The bench SHALL check that a gap of 5 idle cycles with s_valid=0 between load words 9 and 10 leaves the captured n_o unchanged, with RUN entered exactly 1 cycle after word 17.
REQ-042 The bench SHALL check that holding m_ready=0 for 20 cycles on word 3 keeps m_data constant and m_valid=1, with no word skipped or duplicated.
REQ-043 The bench SHALL check that with core_done held at 0 and TIMEOUT=16, SEND is entered after 16 RUN cycles with err=1 and all eight words 0, and that err clears on the next job's word 0.
REQ-044 The bench SHALL check that core_done rising on the timeout cycle produces err=0 and the core result.
REQ-045 The bench SHALL check that rst=0 for one cycle during RUN forces LOAD, core_rst_n=0, s_ready=1 and m_valid=0 on the next cycle.
